// File: rtl/overlay_scheduler.sv
// Frame-synchronous scheduler for full-screen overlay cards: arm, fade in, hold, fade out.
// Define OVERLAY_SCHEDULER_FADE_EN to enable the brightness ramps; otherwise cards cut in/out.
module overlay_scheduler #(
    parameter int unsigned HOLD_FRAMES = 120,
    parameter int unsigned FADE_STEP   = 4
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       req,
    input  logic [1:0] card_id,
    input  logic       abort,
    output logic       overlay_active,
    output logic [1:0] overlay_sel,
    output logic [3:0] brightness,
    output logic       busy,
    output logic       done,
    output logic       overflow
);

    typedef enum logic [2:0] {StIdle, StArm, StFadeIn, StHold, StFadeOut} state_e;

    localparam logic [9:0] HoldLast = 10'(HOLD_FRAMES - 1);

    if (HOLD_FRAMES < 1 || HOLD_FRAMES > 1023) begin : g_bad_hold_frames
        $error("HOLD_FRAMES out of range 1..1023");
    end
    if (FADE_STEP < 1 || FADE_STEP > 15) begin : g_bad_fade_step
        $error("FADE_STEP out of range 1..15");
    end

    state_e     state_q, state_d;
    logic       active_q, active_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] bright_q, bright_d;
    logic       done_q, done_d;
    logic       overflow_q, overflow_d;
    logic       pend_valid_q, pend_valid_d;
    logic [1:0] pend_id_q, pend_id_d;
    logic [9:0] hold_q, hold_d;
    logic       origin_q, tick_q;
    logic       complete, abort_ok;
`ifdef OVERLAY_SCHEDULER_FADE_EN
    localparam logic [3:0] StepLast = 4'(FADE_STEP - 1);
    logic [3:0] step_q, step_d;
`endif

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q      <= StIdle;
            active_q     <= 1'b0;
            sel_q        <= 2'd0;
            bright_q     <= 4'd0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= 2'd0;
            hold_q       <= 10'd0;
            origin_q     <= 1'b0;
            tick_q       <= 1'b0;
`ifdef OVERLAY_SCHEDULER_FADE_EN
            step_q       <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            sel_q        <= sel_d;
            bright_q     <= bright_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            hold_q       <= hold_d;
            // One tick per run of the 0,0 position, however long it is held.
            origin_q     <= (DrawX == 10'd0) && (DrawY == 10'd0);
            tick_q       <= (DrawX == 10'd0) && (DrawY == 10'd0) && !origin_q;
`ifdef OVERLAY_SCHEDULER_FADE_EN
            step_q       <= step_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        sel_d        = sel_q;
        bright_d     = bright_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q;
        pend_valid_d = pend_valid_q;
        pend_id_d    = pend_id_q;
        hold_d       = hold_q;
        complete     = 1'b0;
        abort_ok     = 1'b0;
`ifdef OVERLAY_SCHEDULER_FADE_EN
        step_d       = step_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    sel_d   = card_id;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (abort) begin
                    abort_ok = 1'b1;
                    state_d  = StIdle;
                end else if (tick_q) begin
                    active_d = 1'b1;
`ifdef OVERLAY_SCHEDULER_FADE_EN
                    bright_d = 4'd0;
                    state_d  = StFadeIn;
`else
                    bright_d = 4'd15;
                    state_d  = StHold;
`endif
                end
            end
`ifdef OVERLAY_SCHEDULER_FADE_EN
            StFadeIn: begin
                if (abort) begin
                    abort_ok = 1'b1;
                    state_d  = StFadeOut;
                end else if (tick_q) begin
                    if (step_q == StepLast) begin
                        step_d   = 4'd0;
                        bright_d = bright_q + 4'd1;
                        if (bright_q == 4'd14) state_d = StHold;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
`endif
            StHold: begin
                if (abort || (tick_q && hold_q == HoldLast)) begin
                    abort_ok = abort;
`ifdef OVERLAY_SCHEDULER_FADE_EN
                    state_d  = StFadeOut;
`else
                    complete = 1'b1;
`endif
                end else if (tick_q) begin
                    hold_d = hold_q + 10'd1;
                end
            end
`ifdef OVERLAY_SCHEDULER_FADE_EN
            StFadeOut: begin
                if (tick_q) begin
                    if (step_q == StepLast) begin
                        step_d = 4'd0;
                        if (bright_q <= 4'd1) complete = 1'b1;
                        else bright_d = bright_q - 4'd1;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (abort_ok) pend_valid_d = 1'b0;

        if (complete) begin
            active_d = 1'b0;
            bright_d = 4'd0;
            done_d   = 1'b1;
            if (pend_valid_d) begin
                sel_d        = pend_id_q;
                pend_valid_d = 1'b0;
                state_d      = StArm;
            end else begin
                state_d = StIdle;
            end
        end

        // A busy-time request landing on the completion edge starts directly instead of
        // being parked in a slot that IDLE would never drain.
        if (state_q != StIdle && req && !abort) begin
            if (state_d == StIdle) begin
                sel_d   = card_id;
                state_d = StArm;
            end else if (!pend_valid_d) begin
                pend_valid_d = 1'b1;
                pend_id_d    = card_id;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (state_d != state_q) begin
            hold_d = 10'd0;
`ifdef OVERLAY_SCHEDULER_FADE_EN
            step_d = 4'd0;
`endif
        end
    end

    assign overlay_active = active_q;
    assign overlay_sel    = sel_q;
    assign brightness     = bright_q;
    assign busy           = (state_q != StIdle);
    assign done           = done_q;
    assign overflow       = overflow_q;

endmodule

// File: doc/overlay_scheduler.md
OVERLAY_SCHEDULER -- requirements
Module: overlay_scheduler

Interface
REQ-001 Parameter HOLD_FRAMES, default 120, number of frame ticks an overlay card stays at full brightness (range 1..1023).
REQ-002 Parameter FADE_STEP, default 4, frame ticks per brightness step during fades (range 1..15).
REQ-003 vga_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 DrawX  input  10  current pixel column from the VGA controller.
REQ-006 DrawY  input  10  current pixel row from the VGA controller.
REQ-007 req  input  1  single-cycle request to show a full-screen card.
REQ-008 card_id  input  2  card to show, sampled with req.
REQ-009 abort  input  1  single-cycle request to end the current card early.
REQ-010 overlay_active  output  1  card mapper output overrides gameplay pixels.
REQ-011 overlay_sel  output  2  which card mapper drives the screen.
REQ-012 brightness  output  4  palette scale for the active card; 15 = full.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse when a card finishes.
REQ-015 overflow  output  1  sticky: a request was dropped.

Function
REQ-016 frame_tick SHALL be an internal registered pulse, high for one cycle, one cycle after the first cycle of each run in which DrawX==0 and DrawY==0 (rising-edge detected; a held 0,0 gives one tick).
REQ-017 States SHALL be IDLE, ARM, FADE_IN, HOLD, FADE_OUT.
REQ-018 IDLE: req latches card_id into overlay_sel and moves to ARM next cycle; abort in IDLE is ignored; req and abort together in IDLE SHALL accept req.
REQ-019 ARM: on frame_tick move to FADE_IN with brightness 0 and overlay_active 1 (card switches only on a frame boundary).
REQ-020 FADE_IN: brightness SHALL increment by 1 every FADE_STEP frame ticks; on the tick at which it becomes 15, move to HOLD with hold counter cleared.
REQ-021 HOLD: count frame ticks; on the HOLD_FRAMES-th tick move to FADE_OUT, brightness still 15.
REQ-022 FADE_OUT: brightness SHALL decrement by 1 every FADE_STEP frame ticks; on the edge it reaches 0, overlay_active drops, done pulses for one cycle, and state becomes IDLE, or ARM with the pending card if pending is valid (pending consumed).
REQ-023 Pending slot, one deep: req while busy stores card_id if the slot is empty; if full, request is dropped and overflow set.
REQ-024 abort in ARM SHALL return to IDLE without done and without asserting overlay_active; abort in FADE_IN or HOLD SHALL jump to FADE_OUT from the current brightness; abort in FADE_OUT is ignored; any accepted abort clears the pending slot.
REQ-025 req and abort in the same busy cycle: abort applies and req is dropped without setting overflow.
REQ-026 Fade step counter and hold counter SHALL reset to 0 on every state entry.
REQ-027 overlay_sel SHALL hold its value while not busy; brightness SHALL be 0 whenever overlay_active is 0.

Reset
REQ-028 Reset SHALL force IDLE, overlay_active 0, overlay_sel 0, brightness 0, busy 0, done 0, overflow 0, pending empty, all counters 0, frame-tick edge detector cleared; Reset mid-card SHALL blank the overlay on the next edge with no done pulse.

Configuration
REQ-029 Macro OVERLAY_SCHEDULER_FADE_EN defined: FADE_IN and FADE_OUT operate as REQ-020/REQ-022.
REQ-030 Without OVERLAY_SCHEDULER_FADE_EN: ARM goes to HOLD on frame_tick with brightness 15; HOLD expiry or abort in HOLD goes straight to the REQ-022 completion (brightness 0, overlay_active 0, done pulse) on the same edge; FADE_STEP is unused.

Verification
REQ-031 FADE_EN, HOLD_FRAMES=3, FADE_STEP=1: req card 2 -> overlay_active at first frame_tick, brightness 0..15 over 15 ticks, 3 ticks hold, 15..0, done one cycle, busy low.
REQ-032 Second req card 1 during HOLD, third req during same card -> card 1 starts via ARM after done; overflow=1.
REQ-033 abort at brightness 7 in FADE_IN -> FADE_OUT from 7, done after 7 step ticks; pending cleared.
REQ-034 abort in ARM -> IDLE, no done, overlay_active never high.
REQ-035 FADE_EN undefined, HOLD_FRAMES=2: req -> brightness 15 at first tick, overlay off and done at 2nd following tick.
REQ-036 Reset asserted in HOLD -> all outputs at reset values next cycle, no done; DrawX,DrawY held at 0,0 for 3 cycles -> exactly one frame_tick.
